// File: rtl/shift_pin_sout_pkg.sv
// Shared definitions for the shift_pin_sout transmit path: default sizes, FSM encoding
// and a constant clog2 helper.
package shift_pin_sout_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_pin_sout_sync_rise.sv
// Multi-flop synchroniser for an asynchronous pin followed by a single-cycle
// rising-edge pulse. All flops clear on synchronous reset.
module sync_rise #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/shift_pin_sout.sv
// Parallel-in, serial-out byte transmitter towards the Pi, with a one-deep holding register.
// Define SHIFT_PIN_SOUT_PARITY_EN to append an odd-parity bit after the last data bit.
module shift_pin_sout
  import shift_pin_sout_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:WIDTH-1] pdata,
  input  logic             pvalid,
  output logic             pready,
  input  logic             sclk,
  input  logic             sle,
  output logic             dout,
  output logic             busy,
  output logic             underrun
);

`ifdef SHIFT_PIN_SOUT_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned       CNT_W    = clog2(FRAME + 1);
  localparam logic [CNT_W-1:0]  TERM_CNT = CNT_W'(FRAME);

  logic w_sclk_rise;
  logic w_sle_rise;

  sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (clk),
    .reset   (reset),
    .i_async (sclk),
    .o_rise  (w_sclk_rise)
  );

  sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sle (
    .clk     (clk),
    .reset   (reset),
    .i_async (sle),
    .o_rise  (w_sle_rise)
  );

  state_e           r_state, w_state_d;
  logic [0:WIDTH-1] r_hold, w_hold_d;
  logic             r_hold_valid, w_hold_valid_d;
  logic [0:FRAME-1] r_shift, w_shift_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_dout, w_dout_d;
  logic             r_busy, w_busy_d;
  logic             r_underrun, w_underrun_d;
  logic [0:FRAME-1] w_load_word;

  // An empty holding register loads zeros (and, with parity, a parity bit of 1).
`ifdef SHIFT_PIN_SOUT_PARITY_EN
  assign w_load_word = r_hold_valid ? {r_hold, ~^r_hold} : {{WIDTH{1'b0}}, 1'b1};
`else
  assign w_load_word = r_hold_valid ? r_hold : '0;
`endif

  always_comb begin
    w_state_d      = r_state;
    w_hold_d       = r_hold;
    w_hold_valid_d = r_hold_valid;
    w_shift_d      = r_shift;
    w_cnt_d        = r_cnt;
    w_dout_d       = r_dout;
    w_busy_d       = r_busy;
    w_underrun_d   = 1'b0;

    // Load has priority over a coincident shift and restarts any frame in flight.
    if (w_sle_rise) begin
      w_shift_d      = w_load_word;
      w_cnt_d        = '0;
      w_dout_d       = w_load_word[0];
      w_hold_valid_d = 1'b0;
      w_underrun_d   = ~r_hold_valid;
      w_busy_d       = 1'b1;
      w_state_d      = ST_SHIFT;
    end else if (r_state == ST_SHIFT && w_sclk_rise) begin
      w_shift_d = {r_shift[1:FRAME-1], 1'b0};
      w_cnt_d   = r_cnt + CNT_W'(1);
      if (w_cnt_d == TERM_CNT) begin
        w_dout_d  = 1'b0;
        w_busy_d  = 1'b0;
        w_state_d = ST_IDLE;
      end else begin
        w_dout_d = r_shift[1];
      end
    end

    // A write is only accepted into an empty holding register, so it never clobbers a load.
    if (pvalid && !r_hold_valid) begin
      w_hold_d       = pdata;
      w_hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_dout       <= 1'b0;
      r_busy       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_hold       <= w_hold_d;
      r_hold_valid <= w_hold_valid_d;
      r_shift      <= w_shift_d;
      r_cnt        <= w_cnt_d;
      r_dout       <= w_dout_d;
      r_busy       <= w_busy_d;
      r_underrun   <= w_underrun_d;
    end
  end

  assign pready   = ~r_hold_valid;
  assign dout     = r_dout;
  assign busy     = r_busy;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_shift_pin_sout.sv
// Directed self-checking bench for shift_pin_sout: transfer, double buffering, underrun,
// abort, reset and synchroniser latency (plus parity when SHIFT_PIN_SOUT_PARITY_EN is set).
module tb_shift_pin_sout;

`ifdef SHIFT_PIN_SOUT_PARITY_EN
  localparam int TERM = 9;
`else
  localparam int TERM = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [0:7] pdata = '0;
  logic       pvalid = 1'b0;
  logic       pready;
  logic       sclk = 1'b0;
  logic       sle = 1'b0;
  logic       dout;
  logic       busy;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  shift_pin_sout dut (
    .clk      (clk),
    .reset    (reset),
    .pdata    (pdata),
    .pvalid   (pvalid),
    .pready   (pready),
    .sclk     (sclk),
    .sle      (sle),
    .dout     (dout),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Expected serial bit idx of a frame carrying byte b (idx 8 is the odd-parity bit).
  function automatic logic exp_bit(input logic [0:7] b, input int idx);
    if (idx < 8) return b[idx];
    return ~^b;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    pdata  = b;
    pvalid = 1'b1;
    cycles(1);
    pvalid = 1'b0;
  endtask

  task automatic pulse_sle();
    sle = 1'b1;
    cycles(4);
    sle = 1'b0;
    cycles(4);
  endtask

  task automatic pulse_sclk();
    sclk = 1'b1;
    cycles(4);
    sclk = 1'b0;
    cycles(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(1);
    checks++;
    if ({pready, dout, busy, underrun} !== 4'b1000) begin
      errors++;
      $display("FAIL reset {pready,dout,busy,underrun}: got %b want 1000",
               {pready, dout, busy, underrun});
    end
  endtask

  task automatic test_basic();
    logic [0:7] b;
    b = 8'hA5;
    write_byte(b);
    checks++;
    if (pready !== 1'b0) begin
      errors++; $display("FAIL basic pready after write: got %b want 0", pready);
    end
    pulse_sle();
    checks++;
    if ({dout, busy, pready} !== {b[0], 2'b11}) begin
      errors++; $display("FAIL basic load {dout,busy,pready}: got %b want %b",
                         {dout, busy, pready}, {b[0], 2'b11});
    end
    for (int i = 1; i < TERM; i++) begin
      pulse_sclk();
      checks++;
      if ({dout, busy} !== {exp_bit(b, i), 1'b1}) begin
        errors++; $display("FAIL basic bit %0d {dout,busy}: got %b want %b", i,
                           {dout, busy}, {exp_bit(b, i), 1'b1});
      end
    end
    pulse_sclk();
    checks++;
    if ({dout, busy} !== 2'b00) begin
      errors++; $display("FAIL basic end {dout,busy}: got %b want 00", {dout, busy});
    end
  endtask

  task automatic test_double_buffer();
    logic [0:7] a;
    logic [0:7] c;
    a = 8'h3C;
    c = 8'hC3;
    write_byte(a);
    pulse_sle();
    checks++;
    if ({dout, pready} !== {a[0], 1'b1}) begin
      errors++; $display("FAIL dbuf load1 {dout,pready}: got %b want %b", {dout, pready},
                         {a[0], 1'b1});
    end
    for (int i = 1; i < TERM; i++) begin
      pulse_sclk();
      if (i == 3) write_byte(c);
      checks++;
      if ({dout, pready} !== {exp_bit(a, i), (i < 3)}) begin
        errors++; $display("FAIL dbuf first bit %0d {dout,pready}: got %b want %b", i,
                           {dout, pready}, {exp_bit(a, i), (i < 3)});
      end
    end
    pulse_sclk();
    checks++;
    if ({dout, busy, pready} !== 3'b000) begin
      errors++; $display("FAIL dbuf end1 {dout,busy,pready}: got %b want 000",
                         {dout, busy, pready});
    end
    pulse_sle();
    checks++;
    if ({dout, busy, pready} !== {c[0], 2'b11}) begin
      errors++; $display("FAIL dbuf load2 {dout,busy,pready}: got %b want %b",
                         {dout, busy, pready}, {c[0], 2'b11});
    end
    for (int i = 1; i < TERM; i++) begin
      pulse_sclk();
      checks++;
      if (dout !== exp_bit(c, i)) begin
        errors++; $display("FAIL dbuf second bit %0d: got %b want %b", i, dout, exp_bit(c, i));
      end
    end
    pulse_sclk();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL dbuf end2 busy: got %b want 0", busy);
    end
  endtask

  task automatic test_underrun();
    int pulses;
    pulses = 0;
    sle = 1'b1;
    for (int i = 0; i < 4; i++) begin cycles(1); if (underrun === 1'b1) pulses++; end
    sle = 1'b0;
    for (int i = 0; i < 4; i++) begin cycles(1); if (underrun === 1'b1) pulses++; end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL underrun pulse width: got %0d cycles want 1", pulses);
    end
    checks++;
    if ({dout, busy} !== 2'b01) begin
      errors++; $display("FAIL underrun load {dout,busy}: got %b want 01", {dout, busy});
    end
    for (int i = 1; i < TERM; i++) begin
      pulse_sclk();
      checks++;
      if ({dout, busy} !== {exp_bit(8'h00, i), 1'b1}) begin
        errors++; $display("FAIL underrun bit %0d {dout,busy}: got %b want %b", i,
                           {dout, busy}, {exp_bit(8'h00, i), 1'b1});
      end
    end
    pulse_sclk();
    checks++;
    if ({dout, busy} !== 2'b00) begin
      errors++; $display("FAIL underrun end {dout,busy}: got %b want 00", {dout, busy});
    end
  endtask

  task automatic test_abort();
    logic [0:7] b;
    b = 8'h0F;
    write_byte(8'hFF);
    pulse_sle();
    pulse_sclk();
    pulse_sclk();
    write_byte(b);
    pulse_sle();
    checks++;
    if ({dout, busy, underrun} !== 3'b010) begin
      errors++; $display("FAIL abort reload {dout,busy,underrun}: got %b want 010",
                         {dout, busy, underrun});
    end
    for (int i = 1; i < TERM; i++) begin
      pulse_sclk();
      checks++;
      if ({dout, busy} !== {exp_bit(b, i), 1'b1}) begin
        errors++; $display("FAIL abort bit %0d {dout,busy}: got %b want %b", i,
                           {dout, busy}, {exp_bit(b, i), 1'b1});
      end
    end
    pulse_sclk();
    checks++;
    if ({dout, busy} !== 2'b00) begin
      errors++; $display("FAIL abort end {dout,busy}: got %b want 00", {dout, busy});
    end
  endtask

  task automatic test_reset_mid_shift();
    int pulses;
    write_byte(8'hFF);
    pulse_sle();
    write_byte(8'h81);
    for (int i = 0; i < 4; i++) pulse_sclk();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    checks++;
    if ({dout, busy, pready} !== 3'b001) begin
      errors++; $display("FAIL rstmid {dout,busy,pready}: got %b want 001",
                         {dout, busy, pready});
    end
    pulse_sclk();
    checks++;
    if ({dout, busy} !== 2'b00) begin
      errors++; $display("FAIL rstmid idle sclk {dout,busy}: got %b want 00", {dout, busy});
    end
    pulses = 0;
    sle = 1'b1;
    for (int i = 0; i < 4; i++) begin cycles(1); if (underrun === 1'b1) pulses++; end
    sle = 1'b0;
    for (int i = 0; i < 4; i++) begin cycles(1); if (underrun === 1'b1) pulses++; end
    checks++;
    if (pulses != 1 || dout !== 1'b0) begin
      errors++; $display("FAIL rstmid hold discarded: got underrun=%0d dout=%b want 1 0",
                         pulses, dout);
    end
    for (int i = 0; i < TERM; i++) pulse_sclk();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rstmid drain busy: got %b want 0", busy);
    end
  endtask

  task automatic test_latency();
    logic [0:7] b;
    logic [2:0] seen;
    b = 8'h40;
    write_byte(b);
    pulse_sle();
    sclk = 1'b1;
    for (int i = 0; i < 3; i++) begin cycles(1); seen[i] = dout; end
    checks++;
    if (seen !== 3'b100) begin
      errors++; $display("FAIL latency dout over 3 clks (c3,c2,c1): got %b want 100", seen);
    end
    sclk = 1'b0;
    cycles(4);
    for (int i = 1; i < TERM; i++) pulse_sclk();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL latency drain busy: got %b want 0", busy);
    end
  endtask

`ifdef SHIFT_PIN_SOUT_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes [2];
    logic       par   [2];
    bytes[0] = 8'h01; par[0] = 1'b0;
    bytes[1] = 8'h03; par[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      write_byte(bytes[k]);
      pulse_sle();
      for (int i = 0; i < 8; i++) pulse_sclk();
      checks++;
      if ({dout, busy} !== {par[k], 1'b1}) begin
        errors++; $display("FAIL parity of %h {dout,busy}: got %b want %b", bytes[k],
                           {dout, busy}, {par[k], 1'b1});
      end
      pulse_sclk();
      checks++;
      if ({dout, busy} !== 2'b00) begin
        errors++; $display("FAIL parity end %h {dout,busy}: got %b want 00", bytes[k],
                           {dout, busy});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_double_buffer();
    test_underrun();
    test_abort();
    test_reset_mid_shift();
    test_latency();
`ifdef SHIFT_PIN_SOUT_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
